// File: rtl/recfg_array_stream.sv
// ROWS x COLS reconfigurable PE array: MAC with multi-pass K accumulation and
// element-wise multiply/add modes. Two-stage pipeline (products, then round/saturate).
module recfg_array_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int FRAC_BITS  = 8,
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int KCNT_W     = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [2:0]                      cfg_mode,
  input  logic [KCNT_W-1:0]               cfg_k_len,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ROWS*COLS*DATA_WIDTH-1:0] a_in,
  input  logic [ROWS*DATA_WIDTH-1:0]      b_row,
  input  logic [COLS*DATA_WIDTH-1:0]      b_col,
  input  logic [ROWS*COLS*DATA_WIDTH-1:0] b_mat,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ROWS*DATA_WIDTH-1:0]      out_vec,
  output logic [ROWS*COLS*DATA_WIDTH-1:0] out_mat,
  output logic                            out_shape,
  output logic                            out_sat,
  output logic                            err_mode,
  output logic                            busy,
  output logic                            dbg_state
);
  // Handshake: a beat transfers on in_valid && in_ready, a result on out_valid && out_ready;
  // both stages move together, so in_ready is high exactly when S2 is empty or draining.
  localparam int N  = ROWS * COLS;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int RW = ACC_WIDTH + 1;
  localparam logic signed [RW-1:0] RND  = RW'(1) << (FRAC_BITS - 1);
  localparam logic signed [RW-1:0] SMAX = (RW'(1) << (DATA_WIDTH - 1)) - RW'(1);
  localparam logic signed [RW-1:0] SMIN = -(RW'(1) << (DATA_WIDTH - 1));

  typedef enum logic {ST_IDLE = 1'b0, ST_ACC = 1'b1} state_t;
  state_t state_q, state_d;

  logic [KCNT_W-1:0]           k_len_q, k_len_d, k_cnt_q, k_cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q [ROWS];
  logic signed [ACC_WIDTH-1:0] acc_d [ROWS];
  logic signed [ACC_WIDTH-1:0] mac_new [ROWS];
  logic signed [ACC_WIDTH-1:0] row_sum [ROWS];
  logic signed [ACC_WIDTH-1:0] elem [N];
  logic signed [ACC_WIDTH-1:0] s1_val_q [N];
  logic signed [ACC_WIDTH-1:0] s1_val_d [N];
  logic                        s1_valid_q, s1_valid_d, s1_shape_q, s1_shape_d, s1_shift_q, s1_shift_d;
  logic                        out_valid_q, out_shape_q, out_sat_q, err_q, err_d;
  logic [ROWS*DATA_WIDTH-1:0]  out_vec_q;
  logic [N*DATA_WIDTH-1:0]     out_mat_q;
  logic [DATA_WIDTH-1:0]       res [N];
  logic                        sat_any, mac_fire, advance, accept, is_add, is_mat;
  logic [2:0]                  mode_eff;
  logic signed [PW-1:0]        av, bsel, bcv;
  logic signed [RW-1:0]        wv, rv;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign accept    = in_valid && advance;
  // An open MAC group owns the array: every beat is a MAC pass regardless of cfg_mode.
  assign mode_eff  = (state_q == ST_ACC) ? 3'b000 : cfg_mode;
  assign is_add    = mode_eff inside {3'b100, 3'b101};
  assign is_mat    = mode_eff inside {3'b001, 3'b011, 3'b101, 3'b110};
  assign out_valid = out_valid_q;
  assign out_vec   = out_vec_q;
  assign out_mat   = out_mat_q;
  assign out_shape = out_shape_q;
  assign out_sat   = out_sat_q;
  assign err_mode  = err_q;
  assign busy      = (state_q == ST_ACC) || s1_valid_q || out_valid_q;
  assign dbg_state = (state_q == ST_ACC);

  always_comb begin
    av = '0; bsel = '0; bcv = '0;
    for (int i = 0; i < ROWS; i++) begin
      row_sum[i] = '0;
      for (int j = 0; j < COLS; j++) begin
        av  = PW'($signed(a_in[(i*COLS+j)*DATA_WIDTH +: DATA_WIDTH]));
        bcv = PW'($signed(b_col[j*DATA_WIDTH +: DATA_WIDTH]));
        case (mode_eff)
          3'b000, 3'b011:         bsel = bcv;
          3'b001, 3'b010, 3'b100: bsel = PW'($signed(b_row[i*DATA_WIDTH +: DATA_WIDTH]));
          default:                bsel = PW'($signed(b_mat[(i*COLS+j)*DATA_WIDTH +: DATA_WIDTH]));
        endcase
        elem[i*COLS+j] = ACC_WIDTH'(is_add ? av + bsel : av * bsel);
        row_sum[i]     = row_sum[i] + ACC_WIDTH'(av * bcv);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    k_len_d  = k_len_q;
    k_cnt_d  = k_cnt_q;
    acc_d    = acc_q;
    mac_fire = 1'b0;
    for (int i = 0; i < ROWS; i++) mac_new[i] = ((state_q == ST_ACC) ? acc_q[i] : '0) + row_sum[i];
    if (accept && mode_eff == 3'b000) begin
      if (state_q == ST_IDLE) begin
        k_len_d = (cfg_k_len == '0) ? KCNT_W'(1) : cfg_k_len;
        k_cnt_d = KCNT_W'(1);
        if (cfg_k_len <= KCNT_W'(1)) begin
          mac_fire = 1'b1;
          k_cnt_d  = '0;
          for (int i = 0; i < ROWS; i++) acc_d[i] = '0;
        end else begin
          acc_d   = mac_new;
          state_d = ST_ACC;
        end
      end else begin
        k_cnt_d = k_cnt_q + KCNT_W'(1);
        if (k_cnt_d == k_len_q) begin
          mac_fire = 1'b1;
          k_cnt_d  = '0;
          state_d  = ST_IDLE;
          for (int i = 0; i < ROWS; i++) acc_d[i] = '0;
        end else begin
          acc_d = mac_new;
        end
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_shape_d = s1_shape_q;
    s1_shift_d = s1_shift_q;
    s1_val_d   = s1_val_q;
    err_d      = accept && (mode_eff == 3'b111);
    if (advance) begin
      s1_valid_d = accept && (mode_eff != 3'b111) && ((mode_eff != 3'b000) || mac_fire);
      if (accept) begin
        s1_shape_d = is_mat;
        s1_shift_d = !is_add;
        s1_val_d   = elem;
        if (mode_eff == 3'b000)
          for (int i = 0; i < ROWS; i++) s1_val_d[i*COLS] = mac_new[i];
      end
    end
  end

  // Rounding is done one bit wider than the accumulator so the half-LSB add cannot wrap.
  always_comb begin
    wv = '0; rv = '0; sat_any = 1'b0;
    for (int n = 0; n < N; n++) begin
      wv = RW'(s1_val_q[n]);
      rv = s1_shift_q ? ((wv + RND) >>> FRAC_BITS) : wv;
      if (rv > SMAX) begin
        res[n] = SMAX[DATA_WIDTH-1:0];
        if (s1_shape_q || (n % COLS) == 0) sat_any = 1'b1;
      end else if (rv < SMIN) begin
        res[n] = SMIN[DATA_WIDTH-1:0];
        if (s1_shape_q || (n % COLS) == 0) sat_any = 1'b1;
      end else begin
        res[n] = rv[DATA_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_len_q     <= '0;
      k_cnt_q     <= '0;
      for (int i = 0; i < ROWS; i++) acc_q[i] <= '0;
      s1_valid_q  <= 1'b0;
      s1_shape_q  <= 1'b0;
      s1_shift_q  <= 1'b0;
      for (int n = 0; n < N; n++) s1_val_q[n] <= '0;
      out_valid_q <= 1'b0;
      out_shape_q <= 1'b0;
      out_sat_q   <= 1'b0;
      out_vec_q   <= '0;
      out_mat_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_len_q    <= k_len_d;
      k_cnt_q    <= k_cnt_d;
      acc_q      <= acc_d;
      s1_valid_q <= s1_valid_d;
      s1_shape_q <= s1_shape_d;
      s1_shift_q <= s1_shift_d;
      s1_val_q   <= s1_val_d;
      err_q      <= err_d;
      if (advance) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_shape_q <= s1_shape_q;
          out_sat_q   <= sat_any;
          if (s1_shape_q) begin
            for (int n = 0; n < N; n++) out_mat_q[n*DATA_WIDTH +: DATA_WIDTH] <= res[n];
          end else begin
            for (int i = 0; i < ROWS; i++) out_vec_q[i*DATA_WIDTH +: DATA_WIDTH] <= res[i*COLS];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_recfg_array_stream.sv
// Bench for recfg_array_stream: directed steps plus a random stream, checked against
// an arithmetic model that queues each expected result as {shape, sat, field}.
`timescale 1ns/1ps
module tb_recfg_array_stream;
  localparam int DW = 16, R = 8, C = 8, KW = 8;
  localparam int MW = R*C*DW, VW = R*DW, CW = C*DW, EW = MW + 2;

  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] cfg_mode = '0;
  logic [KW-1:0] cfg_k_len = '0;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_shape, out_sat, err_mode, busy, dbg_state;
  logic [MW-1:0] a_in = '0, b_mat = '0, out_mat;
  logic [VW-1:0] b_row = '0, out_vec;
  logic [CW-1:0] b_col = '0;
  logic [MW-1:0] st_a, st_bm;
  logic [VW-1:0] st_br;
  logic [CW-1:0] st_bc;

  int n_tests = 0, n_fail = 0;
  logic [EW-1:0] exp_q[$];
  bit m_grp = 0;
  int m_klen = 1, m_cnt = 0;
  int m_acc [R];
  bit rdone;

  recfg_array_stream dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_k_len(cfg_k_len),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_row(b_row),
    .b_col(b_col), .b_mat(b_mat), .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_mat(out_mat), .out_shape(out_shape), .out_sat(out_sat),
    .err_mode(err_mode), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic got, input logic exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
    end
  endtask

  function automatic int ga(int i, int j); return int'($signed(a_in[(i*C+j)*DW +: DW])); endfunction
  function automatic int gr(int i);        return int'($signed(b_row[i*DW +: DW]));       endfunction
  function automatic int gc(int j);        return int'($signed(b_col[j*DW +: DW]));       endfunction
  function automatic int gm(int i, int j); return int'($signed(b_mat[(i*C+j)*DW +: DW])); endfunction

  function automatic longint rnd(input longint p);
    return (p + 128) >>> 8;
  endfunction

  function automatic logic [16:0] satv(input longint v);
    logic [63:0] u;
    u = v;
    if (v > 32767)  return {1'b1, 16'h7fff};
    if (v < -32768) return {1'b1, 16'h8000};
    return {1'b0, u[15:0]};
  endfunction

  // Called just before the edge that accepts the beat now on the DUT inputs.
  task automatic model_accept(input logic [2:0] mode, input logic [KW-1:0] k);
    logic [2:0] m;
    logic [16:0] sv;
    logic [MW-1:0] f;
    bit s;
    int b;
    longint v;
    m = m_grp ? 3'b000 : mode;
    s = 0;
    f = '0;
    if (m == 3'b111) return;
    if (m == 3'b000) begin
      if (!m_grp) begin
        m_klen = (k == 0) ? 1 : int'(k);
        m_cnt  = 0;
        for (int i = 0; i < R; i++) m_acc[i] = 0;
      end
      for (int i = 0; i < R; i++)
        for (int j = 0; j < C; j++) m_acc[i] += ga(i, j) * gc(j);
      m_cnt++;
      if (m_cnt < m_klen) begin
        m_grp = 1;
        return;
      end
      m_grp = 0;
      for (int i = 0; i < R; i++) begin
        sv = satv(rnd(longint'(m_acc[i])));
        s |= sv[16];
        f[i*DW +: DW] = sv[15:0];
      end
      exp_q.push_back({1'b0, s, f});
      return;
    end
    for (int i = 0; i < R; i++) begin
      for (int j = 0; j < C; j++) begin
        if (m == 3'b011) b = gc(j);
        else if (m == 3'b001 || m == 3'b010 || m == 3'b100) b = gr(i);
        else b = gm(i, j);
        if (m == 3'b100 || m == 3'b101) v = longint'(ga(i, j) + b);
        else v = rnd(longint'(ga(i, j)) * b);
        sv = satv(v);
        if (m == 3'b010 || m == 3'b100) begin
          if (j == 0) begin
            f[i*DW +: DW] = sv[15:0];
            s |= sv[16];
          end
        end else begin
          f[(i*C+j)*DW +: DW] = sv[15:0];
          s |= sv[16];
        end
      end
    end
    exp_q.push_back({(m == 3'b001 || m == 3'b011 || m == 3'b101 || m == 3'b110), s, f});
  endtask

  function automatic logic [15:0] rv16();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return 16'(int'($urandom_range(0, 1536)) - 768);
  endfunction

  task automatic rand_stage();
    for (int n = 0; n < R*C; n++) begin
      st_a[n*DW +: DW]  = rv16();
      st_bm[n*DW +: DW] = rv16();
    end
    for (int i = 0; i < R; i++) st_br[i*DW +: DW] = rv16();
    for (int j = 0; j < C; j++) st_bc[j*DW +: DW] = rv16();
  endtask

  task automatic fill_stage(input logic [15:0] av, input logic [15:0] bv);
    for (int n = 0; n < R*C; n++) begin
      st_a[n*DW +: DW]  = av;
      st_bm[n*DW +: DW] = bv;
    end
    for (int i = 0; i < R; i++) st_br[i*DW +: DW] = bv;
    for (int j = 0; j < C; j++) st_bc[j*DW +: DW] = bv;
  endtask

  // Drive one beat and hold it until the DUT is ready; returns just before the accepting edge.
  task automatic send(input logic [2:0] m, input logic [KW-1:0] k);
    int n;
    n = 0;
    @(posedge clk); #2;
    a_in = st_a; b_row = st_br; b_col = st_bc; b_mat = st_bm;
    cfg_mode = m; cfg_k_len = k; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #3;
      n++;
    end
    chkb("in_ready_wait", in_ready, 1'b1);
    if (in_ready) model_accept(m, k);
  endtask

  task automatic idle();
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    chkb("drain_empty", exp_q.size() == 0, 1'b1);
  endtask

  logic [EW-1:0] got, hold_m, hold_v;
  bit hold_p = 0;
  always @(negedge clk) begin
    if (rst) begin
      hold_p = 0;
    end else begin
      if (hold_p && out_valid) begin
        chk("hold_mat", {out_shape, out_sat, out_mat}, hold_m);
        chk("hold_vec", EW'(out_vec), hold_v);
      end
      hold_p = 0;
      if (out_valid && !out_ready) begin
        hold_p = 1;
        hold_m = {out_shape, out_sat, out_mat};
        hold_v = EW'(out_vec);
      end
      if (out_valid && out_ready) begin
        got = {out_shape, out_sat, out_shape ? out_mat : MW'(out_vec)};
        n_tests++;
        assert (exp_q.size() > 0) else begin
          n_fail++;
          $error("FAIL unexpected_out got=%0h exp=none", got);
        end
        if (exp_q.size() > 0) chk("result", got, exp_q.pop_front());
      end
    end
  end

  initial begin
    st_a = '0; st_br = '0; st_bc = '0; st_bm = '0;
    repeat (3) @(posedge clk);
    #3;
    chkb("rst_out_valid", out_valid, 1'b0);
    chkb("rst_out_shape", out_shape, 1'b0);
    chkb("rst_out_sat", out_sat, 1'b0);
    chkb("rst_err_mode", err_mode, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_state_idle", dbg_state, 1'b0);
    chk("rst_out_vec", EW'(out_vec), '0);
    chk("rst_out_mat", EW'(out_mat), '0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Mode 010: 1.5 * 2.0 in column 0, two-cycle latency.
    rand_stage();
    for (int i = 0; i < R; i++) begin
      st_a[(i*C)*DW +: DW] = 16'h0180;
      st_br[i*DW +: DW]    = 16'h0200;
    end
    send(3'b010, 8'd0);
    idle();
    @(negedge clk);
    chkb("lat_n1_valid", out_valid, 1'b0);
    @(negedge clk);
    chkb("lat_n2_valid", out_valid, 1'b1);
    chk("vec_1p5x2", EW'(out_vec), EW'({R{16'h0300}}));
    drain();

    // Three-pass MAC of ones: each row sums to 24.0.
    fill_stage(16'h0100, 16'h0100);
    send(3'b000, 8'd3);
    send(3'b111, 8'd9);
    send(3'b101, 8'd1);
    idle();
    #1;
    chkb("mac_busy", busy, 1'b1);
    chkb("mac_state_done", dbg_state, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("mac_k3_vec", EW'(out_vec), EW'({R{16'h1800}}));
    drain();
    chkb("mac_busy_clear", busy, 1'b0);

    // Element-wise add saturating both ways.
    fill_stage(16'h7F00, 16'h0200);
    send(3'b101, 8'd0);
    fill_stage(16'h8000, 16'hFF00);
    send(3'b101, 8'd0);
    idle();
    drain();

    // Four row-broadcast multiplies with a five-cycle downstream stall.
    fork
      begin
        for (int t = 0; t < 4; t++) begin
          rand_stage();
          send(3'b001, 8'd0);
        end
        idle();
      end
      begin
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
          @(posedge clk); #2;
          n++;
        end
        out_ready = 1'b0;
        repeat (5) begin
          #1;
          chkb("stall_in_ready", in_ready, 1'b0);
          @(posedge clk); #2;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Illegal mode: dropped, one-cycle error pulse.
    rand_stage();
    send(3'b111, 8'd0);
    idle();
    @(negedge clk);
    chkb("err_pulse_hi", err_mode, 1'b1);
    @(negedge clk);
    chkb("err_pulse_lo", err_mode, 1'b0);
    drain();

    // Random stream with random back-pressure.
    rdone = 0;
    fork
      begin
        for (int t = 0; t < 60; t++) begin
          rand_stage();
          send(3'($urandom_range(0, 7)), KW'($urandom_range(0, 3)));
        end
        idle();
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge clk); #2;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a 4-pass MAC group; the next group must start clean.
    rand_stage();
    send(3'b000, 8'd4);
    rand_stage();
    send(3'b000, 8'd4);
    idle();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    m_grp = 0;
    exp_q.delete();
    chkb("mid_rst_valid", out_valid, 1'b0);
    chkb("mid_rst_busy", busy, 1'b0);
    chkb("mid_rst_state", dbg_state, 1'b0);
    chkb("mid_rst_sat", out_sat, 1'b0);
    chk("mid_rst_vec", EW'(out_vec), '0);
    chk("mid_rst_mat", EW'(out_mat), '0);
    @(posedge clk); #2;
    rst = 1'b0;
    rand_stage();
    send(3'b000, 8'd1);
    idle();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
